// File: rtl/i2s_pkg.sv
// Shared I2S types and constants for the audio capture and playback blocks.
// Used by i2s_rx today; i2s_tx is expected to import it as well.
package i2s_pkg;

    localparam int I2S_WORD_W = 16;

    typedef enum logic {
        CH_L,
        CH_R
    } chan_t;

    typedef enum logic [1:0] {
        HUNT,
        SKIP,
        SHIFT,
        DONE
    } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, followed by a single
// history flop that yields rise/fall pulses aligned to the synchronised level.
module i2s_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic mclk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: every flop here is cleared on reset so no phantom edge is seen after release.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/wclk/din with mclk, deserialises one left
// and one right word per frame and flags slots that end too early.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  mclk,
    input  logic                  reset_n,
    input  logic                  bclk,
    input  logic                  wclk,
    input  logic                  din,
    output logic [I2S_WORD_W-1:0] rx_data_l,
    output logic [I2S_WORD_W-1:0] rx_data_r,
    output logic                  rx_data_valid,
    output logic                  frame_err
);

    localparam logic [4:0] DEPTH_CNT = 5'(SAMPLE_DEPTH);

    logic bclk_fall, wclk_rise, wclk_fall, din_s, wclk_edge;
    logic bclk_lvl_unused, bclk_rise_unused, wclk_lvl_unused;
    logic din_rise_unused, din_fall_unused;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .mclk(mclk), .reset_n(reset_n), .async_in(bclk),
        .level(bclk_lvl_unused), .rise(bclk_rise_unused), .fall(bclk_fall)
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wclk (
        .mclk(mclk), .reset_n(reset_n), .async_in(wclk),
        .level(wclk_lvl_unused), .rise(wclk_rise), .fall(wclk_fall)
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
        .mclk(mclk), .reset_n(reset_n), .async_in(din),
        .level(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    assign wclk_edge = wclk_rise | wclk_fall;

    rx_state_t               state_q, state_d;
    chan_t                   chan_q, chan_d, edge_chan;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_DEPTH-1:0] sreg_q, sreg_d, hold_l_q, hold_l_d;
    logic                    left_pend_q, left_pend_d;
    logic [I2S_WORD_W-1:0]   data_l_d, data_r_d;
    logic                    valid_d, err_d;

    function automatic logic [I2S_WORD_W-1:0] msb_align(input logic [SAMPLE_DEPTH-1:0] w);
        logic [I2S_WORD_W-1:0] r;
        r = '0;
        r[I2S_WORD_W-1 -: SAMPLE_DEPTH] = w;
        return r;
    endfunction

    // A wclk edge resynchronises the channel by its direction, never by toggling.
    assign edge_chan = wclk_rise ? CH_L : CH_R;

    // NOTE: every signal gets a default first so this block cannot infer latches.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        bit_cnt_d   = bit_cnt_q;
        sreg_d      = sreg_q;
        hold_l_d    = hold_l_q;
        left_pend_d = left_pend_q;
        data_l_d    = rx_data_l;
        data_r_d    = rx_data_r;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            HUNT: begin
                if (wclk_rise) begin
                    state_d     = SKIP;
                    chan_d      = CH_L;
                    left_pend_d = 1'b0;
                end
            end
            SKIP, SHIFT: begin
                if (wclk_edge) begin
                    // Slot ended before a full word arrived: abandon this frame.
                    err_d       = 1'b1;
                    left_pend_d = 1'b0;
                    chan_d      = edge_chan;
                    bit_cnt_d   = '0;
                    state_d     = bclk_fall ? SHIFT : SKIP;
                end else if (bclk_fall) begin
                    if (state_q == SKIP) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        sreg_d    = {sreg_q[SAMPLE_DEPTH-2:0], din_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q + 5'd1 == DEPTH_CNT) state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (wclk_edge) begin
                    if (chan_q == CH_L) begin
                        hold_l_d    = sreg_q;
                        left_pend_d = 1'b1;
                    end else if (left_pend_q) begin
                        data_l_d    = msb_align(hold_l_q);
                        data_r_d    = msb_align(sreg_q);
                        valid_d     = 1'b1;
                        left_pend_d = 1'b0;
                    end
                    chan_d    = edge_chan;
                    bit_cnt_d = '0;
                    state_d   = bclk_fall ? SHIFT : SKIP;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            chan_q        <= CH_L;
            bit_cnt_q     <= '0;
            sreg_q        <= '0;
            hold_l_q      <= '0;
            left_pend_q   <= 1'b0;
            rx_data_l     <= '0;
            rx_data_r     <= '0;
            rx_data_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            bit_cnt_q     <= bit_cnt_d;
            sreg_q        <= sreg_d;
            hold_l_q      <= hold_l_d;
            left_pend_q   <= left_pend_d;
            rx_data_l     <= data_l_d;
            rx_data_r     <= data_r_d;
            rx_data_valid <= valid_d;
            frame_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a behavioural I2S transmitter drives both a
// 16-bit and a 12-bit receiver; expected words are hand-computed constants.
module tb_i2s_rx;

    logic        mclk;
    logic        reset_n;
    logic        bclk;
    logic        wclk;
    logic        din;
    logic [15:0] rx_data_l, rx_data_r, rx12_l, rx12_r;
    logic        rx_data_valid, frame_err, rx12_valid, rx12_err;

    int total = 0;
    int bad   = 0;

    int          v16 = 0, e16 = 0, v12 = 0, e12 = 0;
    logic [15:0] l16 = '0, r16 = '0, l12 = '0, r12 = '0;

    i2s_rx dut (
        .mclk(mclk), .reset_n(reset_n), .bclk(bclk), .wclk(wclk), .din(din),
        .rx_data_l(rx_data_l), .rx_data_r(rx_data_r),
        .rx_data_valid(rx_data_valid), .frame_err(frame_err)
    );

    i2s_rx #(.SAMPLE_DEPTH(12)) dut12 (
        .mclk(mclk), .reset_n(reset_n), .bclk(bclk), .wclk(wclk), .din(din),
        .rx_data_l(rx12_l), .rx_data_r(rx12_r),
        .rx_data_valid(rx12_valid), .frame_err(rx12_err)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // Pulse monitor sampled on the falling edge, away from the active edge.
    always @(negedge mclk) begin
        if (rx_data_valid) begin
            v16 = v16 + 1;
            l16 = rx_data_l;
            r16 = rx_data_r;
        end
        if (frame_err) e16 = e16 + 1;
        if (rx12_valid) begin
            v12 = v12 + 1;
            l12 = rx12_l;
            r12 = rx12_r;
        end
        if (rx12_err) e12 = e12 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // One slot: wclk changes with the first bclk rise, MSB follows one bclk later.
    task automatic send_slot(input logic lvl, input logic [31:0] data, input int nbits, input int len);
        for (int k = 0; k < len; k++) begin
            bclk = 1'b1;
            if (k == 0) wclk = lvl;
            din = (k >= 1 && k <= nbits) ? data[nbits-k] : 1'b0;
            tick(4);
            bclk = 1'b0;
            tick(4);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bclk    = 1'b0;
        wclk    = 1'b0;
        din     = 1'b0;
        tick(4);
        reset_n = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bclk    = 1'b0;
        wclk    = 1'b0;
        din     = 1'b0;
        tick(3);
        if (rx_data_l !== 16'h0) begin bad++; $display("FAIL reset_l got=%h exp=0000", rx_data_l); end
        total++;
        if (rx_data_r !== 16'h0) begin bad++; $display("FAIL reset_r got=%h exp=0000", rx_data_r); end
        total++;
        if (rx_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_data_valid); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        total++;
        if (rx12_l !== 16'h0) begin bad++; $display("FAIL reset_l12 got=%h exp=0000", rx12_l); end
        total++;
        reset_n = 1'b1;
        tick(4);
    endtask

    task automatic test_loopback();
        int v0, e0;
        apply_reset();
        v0 = v16;
        e0 = e16;
        send_slot(1'b1, 32'hA5C3, 16, 32);
        send_slot(1'b0, 32'h1234, 16, 32);
        send_slot(1'b1, 32'hFFFF, 16, 32);
        if (v16 - v0 !== 1) begin bad++; $display("FAIL loop_cnt1 got=%0d exp=1", v16 - v0); end
        total++;
        if (l16 !== 16'hA5C3) begin bad++; $display("FAIL loop_l1 got=%h exp=a5c3", l16); end
        total++;
        if (r16 !== 16'h1234) begin bad++; $display("FAIL loop_r1 got=%h exp=1234", r16); end
        total++;
        send_slot(1'b0, 32'h0000, 16, 32);
        send_slot(1'b1, 32'h0000, 16, 32);
        if (v16 - v0 !== 2) begin bad++; $display("FAIL loop_cnt2 got=%0d exp=2", v16 - v0); end
        total++;
        if (l16 !== 16'hFFFF) begin bad++; $display("FAIL loop_l2 got=%h exp=ffff", l16); end
        total++;
        if (r16 !== 16'h0000) begin bad++; $display("FAIL loop_r2 got=%h exp=0000", r16); end
        total++;
        if (rx_data_l !== 16'hFFFF) begin bad++; $display("FAIL loop_hold got=%h exp=ffff", rx_data_l); end
        total++;
        if (e16 - e0 !== 0) begin bad++; $display("FAIL loop_err got=%0d exp=0", e16 - e0); end
        total++;
    endtask

    task automatic test_mid_frame();
        int v0, e0;
        reset_n = 1'b0;
        send_slot(1'b1, 32'hDEAD, 16, 8);
        send_slot(1'b0, 32'hBEEF, 16, 8);
        reset_n = 1'b1;
        v0 = v16;
        e0 = e16;
        send_slot(1'b0, 32'hBEEF, 16, 20);
        send_slot(1'b1, 32'hC0DE, 16, 32);
        send_slot(1'b0, 32'h7E57, 16, 32);
        if (v16 - v0 !== 0) begin bad++; $display("FAIL mid_early got=%0d exp=0", v16 - v0); end
        total++;
        send_slot(1'b1, 32'h0000, 16, 32);
        if (v16 - v0 !== 1) begin bad++; $display("FAIL mid_cnt got=%0d exp=1", v16 - v0); end
        total++;
        if (l16 !== 16'hC0DE) begin bad++; $display("FAIL mid_l got=%h exp=c0de", l16); end
        total++;
        if (r16 !== 16'h7E57) begin bad++; $display("FAIL mid_r got=%h exp=7e57", r16); end
        total++;
        if (e16 - e0 !== 0) begin bad++; $display("FAIL mid_err got=%0d exp=0", e16 - e0); end
        total++;
    endtask

    task automatic test_short_slot();
        int v0, e0;
        apply_reset();
        v0 = v16;
        e0 = e16;
        send_slot(1'b1, 32'h5555, 16, 10);
        send_slot(1'b0, 32'h9999, 16, 32);
        if (e16 - e0 !== 1) begin bad++; $display("FAIL short_err got=%0d exp=1", e16 - e0); end
        total++;
        send_slot(1'b1, 32'h0F0F, 16, 32);
        if (v16 - v0 !== 0) begin bad++; $display("FAIL short_novalid got=%0d exp=0", v16 - v0); end
        total++;
        send_slot(1'b0, 32'hF0F0, 16, 32);
        send_slot(1'b1, 32'h0000, 16, 32);
        if (v16 - v0 !== 1) begin bad++; $display("FAIL short_cnt got=%0d exp=1", v16 - v0); end
        total++;
        if (l16 !== 16'h0F0F) begin bad++; $display("FAIL short_l got=%h exp=0f0f", l16); end
        total++;
        if (r16 !== 16'hF0F0) begin bad++; $display("FAIL short_r got=%h exp=f0f0", r16); end
        total++;
        if (e16 - e0 !== 1) begin bad++; $display("FAIL short_err_total got=%0d exp=1", e16 - e0); end
        total++;
    endtask

    task automatic test_long_slot();
        int v0, e0;
        apply_reset();
        v0 = v16;
        e0 = e16;
        send_slot(1'b1, 32'hABCDEF, 24, 24);
        send_slot(1'b0, 32'h123456, 24, 24);
        send_slot(1'b1, 32'h000000, 24, 24);
        if (v16 - v0 !== 1) begin bad++; $display("FAIL long_cnt got=%0d exp=1", v16 - v0); end
        total++;
        if (l16 !== 16'hABCD) begin bad++; $display("FAIL long_l got=%h exp=abcd", l16); end
        total++;
        if (r16 !== 16'h1234) begin bad++; $display("FAIL long_r got=%h exp=1234", r16); end
        total++;
        if (e16 - e0 !== 0) begin bad++; $display("FAIL long_err got=%0d exp=0", e16 - e0); end
        total++;
    endtask

    task automatic test_depth12();
        int v0, e0;
        apply_reset();
        v0 = v12;
        e0 = e12;
        send_slot(1'b1, 32'hFFFF, 16, 32);
        send_slot(1'b0, 32'h8421, 16, 32);
        send_slot(1'b1, 32'h0000, 16, 32);
        if (v12 - v0 !== 1) begin bad++; $display("FAIL d12_cnt got=%0d exp=1", v12 - v0); end
        total++;
        if (l12 !== 16'hFFF0) begin bad++; $display("FAIL d12_l got=%h exp=fff0", l12); end
        total++;
        if (r12 !== 16'h8420) begin bad++; $display("FAIL d12_r got=%h exp=8420", r12); end
        total++;
        if (l16 !== 16'hFFFF) begin bad++; $display("FAIL d16_l got=%h exp=ffff", l16); end
        total++;
        if (e12 - e0 !== 0) begin bad++; $display("FAIL d12_err got=%0d exp=0", e12 - e0); end
        total++;
    endtask

    task automatic test_reset_mid_op();
        int v0, e0;
        apply_reset();
        send_slot(1'b1, 32'h1111, 16, 32);
        send_slot(1'b0, 32'h2222, 16, 32);
        send_slot(1'b1, 32'h3333, 16, 32);
        if (rx_data_l !== 16'h1111) begin bad++; $display("FAIL rmid_pre_l got=%h exp=1111", rx_data_l); end
        total++;
        send_slot(1'b0, 32'h4444, 16, 12);
        reset_n = 1'b0;
        #2;
        if (rx_data_l !== 16'h0) begin bad++; $display("FAIL rmid_async_l got=%h exp=0000", rx_data_l); end
        total++;
        if (rx_data_r !== 16'h0) begin bad++; $display("FAIL rmid_async_r got=%h exp=0000", rx_data_r); end
        total++;
        if (rx_data_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async_pulses got=%b%b exp=00", rx_data_valid, frame_err);
        end
        total++;
        tick(2);
        reset_n = 1'b1;
        v0 = v16;
        e0 = e16;
        send_slot(1'b0, 32'h4444, 16, 10);
        send_slot(1'b1, 32'h5A5A, 16, 32);
        if (v16 - v0 !== 0) begin bad++; $display("FAIL rmid_stale got=%0d exp=0", v16 - v0); end
        total++;
        send_slot(1'b0, 32'hA5A5, 16, 32);
        send_slot(1'b1, 32'h0000, 16, 32);
        if (v16 - v0 !== 1) begin bad++; $display("FAIL rmid_cnt got=%0d exp=1", v16 - v0); end
        total++;
        if (l16 !== 16'h5A5A) begin bad++; $display("FAIL rmid_l got=%h exp=5a5a", l16); end
        total++;
        if (r16 !== 16'hA5A5) begin bad++; $display("FAIL rmid_r got=%h exp=a5a5", r16); end
        total++;
        if (e16 - e0 !== 0) begin bad++; $display("FAIL rmid_err got=%0d exp=0", e16 - e0); end
        total++;
    endtask

    initial begin
        reset_n = 1'b0;
        bclk    = 1'b0;
        wclk    = 1'b0;
        din     = 1'b0;
        test_reset();
        test_loopback();
        test_mid_frame();
        test_short_slot();
        test_long_slot();
        test_depth12();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
